// File: rtl/cnt_cmd_sched_if.sv
// ---------------------------------------------------------------------------
// cnt_cmd_sched_if
//   Valid/ready command channel between a count-value producer and the
//   cnt_cmd_sched command sequencer.
//
//   Signals:
//     cmd_valid  producer has a command
//     cmd_ready  sequencer FIFO can accept a command
//     cmd_val    requested count value (CNT_WIDTH bits)
//
//   Modports:
//     master  producer side (drives valid/val, observes ready)
//     slave   sequencer side (observes valid/val, drives ready)
// ---------------------------------------------------------------------------
interface cnt_cmd_sched_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CNT_WIDTH-1:0] cmd_val;

  modport master (output cmd_valid, output cmd_val, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_val, output cmd_ready);
endinterface

// File: rtl/cnt_cmd_sched.sv
// ---------------------------------------------------------------------------
// cnt_cmd_sched
//   Command sequencer sitting in front of the counter/read-FSM pair. Count
//   values arrive over a valid/ready channel into a small FIFO; one run at a
//   time is launched into the counter with a single-cycle start pulse, and the
//   next run is held off until the current one reports done plus a fixed gap.
//
//   Ports:
//     clk         system clock, rising edge
//     rst         asynchronous active-high reset
//     cmd         command channel (slave modport of cnt_cmd_sched_if)
//     flush_i     synchronous FIFO clear (does not abort the current run)
//     start_o     one-cycle launch pulse to the counter FSM
//     cnt_val_o   count value of the current run
//     idle_i      counter FSM is idle
//     done_i      counter FSM done pulse
//     busy_o      a run is launched, in flight or in its gap
//     fifo_cnt_o  FIFO occupancy
//     done_cnt_o  completed-run tally, wraps at 2^16
//     timeout_o   watchdog pulse
//
//   Build option:
//     CNT_CMD_SCHED_TIMEOUT_EN  when defined, a watchdog aborts a run that has
//                               waited 2^CNT_WIDTH+4 cycles without done_i.
//                               When undefined, timeout_o is tied low.
// ---------------------------------------------------------------------------
module cnt_cmd_sched #(
  parameter int CNT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  cnt_cmd_sched_if.slave                cmd,
  input  logic                          flush_i,
  output logic                          start_o,
  output logic [CNT_WIDTH-1:0]          cnt_val_o,
  input  logic                          idle_i,
  input  logic                          done_i,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic [15:0]                   done_cnt_o,
  output logic                          timeout_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [CNT_WIDTH-1:0] head;
  logic [CNT_WIDTH-1:0] cnt_val_q;
  logic [GW-1:0]        gap_cnt;
  logic [15:0]          done_cnt;
  logic                 full, empty, push, pop, wd_hit;

  // Ready comes from registered occupancy only, so a pop in the same cycle
  // never opens a full FIFO; flush wins over a concurrent push.
  assign full          = (count == DEPTH_CNT);
  assign empty         = (count == '0);
  assign head          = mem[rd_ptr];
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full && !flush_i;
  assign pop           = (state_q == IDLE) && !empty && idle_i;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd.cmd_val;
    end
  end

  // Flush still lets a same-cycle pop take the head, then leaves both
  // pointers together just past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= rd_ptr + AW'(pop);
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

`ifdef CNT_CMD_SCHED_TIMEOUT_EN
  localparam int              WDW     = CNT_WIDTH + 3;
  localparam logic [WDW-1:0]  WD_LAST = WDW'((2 ** CNT_WIDTH) + 3);

  logic [WDW-1:0] wd_cnt;
  logic           timeout_q;

  // Counter is held at zero outside WAIT, so it starts fresh on every entry.
  assign wd_hit = (state_q == WAIT) && !done_i && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_hit;
      if (state_q != WAIT) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wd_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // A popped zero command is discarded: the FSM simply stays in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop && (head != '0)) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (done_i || wd_hit) state_d = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_val_q <= '0;
      gap_cnt   <= '0;
      done_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        cnt_val_q <= head;
      end
      if (state_q == GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
      if ((state_q == WAIT) && done_i) begin
        done_cnt <= done_cnt + 16'd1;
      end
    end
  end

  assign start_o    = (state_q == LAUNCH);
  assign busy_o     = (state_q != IDLE);
  assign cnt_val_o  = cnt_val_q;
  assign fifo_cnt_o = count;
  assign done_cnt_o = done_cnt;

endmodule

// File: tb/tb_cnt_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_cnt_cmd_sched
//   Directed bench for cnt_cmd_sched with default parameters. Accepted
//   nonzero commands are queued as expected launches; every start_o pulse
//   pops the queue and checks cnt_val_o and the spacing from the last done.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cnt_cmd_sched;
  localparam int CNT_WIDTH  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_CYCLES = 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 flush, idle, done;
  logic                 start, busy, timeout;
  logic [CNT_WIDTH-1:0] cnt_val;
  logic [2:0]           fifo_cnt;
  logic [15:0]          done_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int starts = 0;
  int last_done_edge = -1000;
  int n;
  logic [CNT_WIDTH-1:0] sb_q[$];

  cnt_cmd_sched_if #(.CNT_WIDTH(CNT_WIDTH)) cmd_if ();

  cnt_cmd_sched #(
    .CNT_WIDTH (CNT_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if.slave),
    .flush_i   (flush),
    .start_o   (start),
    .cnt_val_o (cnt_val),
    .idle_i    (idle),
    .done_i    (done),
    .busy_o    (busy),
    .fifo_cnt_o(fifo_cnt),
    .done_cnt_o(done_cnt),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: each launch must match the oldest accepted command.
  always @(negedge clk) begin
    if (!rst && start) begin
      starts++;
      if (sb_q.size() == 0) begin
        checkOutput("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      end else begin
        checkOutput("cnt_val", 32'(cnt_val), 32'(sb_q.pop_front()));
      end
      checkOutput("spacing", 32'((cyc - last_done_edge) >= GAP_CYCLES + 1), 32'd1);
    end
  end

  // Offer one command and hold it until the FIFO takes it.
  task automatic applyStimulus(input logic [CNT_WIDTH-1:0] v);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_val   = v;
    for (int i = 0; i < 64 && !cmd_if.cmd_ready; i++) @(negedge clk);
    checkOutput("push_ready", 32'(cmd_if.cmd_ready), 32'd1);
    if (cmd_if.cmd_ready && v != '0 && !flush) sb_q.push_back(v);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_start();
    logic seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (start) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("start_seen", 32'(seen), 32'd1);
  endtask

  task automatic finish_run(input int len);
    repeat (len) @(negedge clk);
    done = 1'b1;
    last_done_edge = cyc + 1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic run_done(input int len);
    wait_start();
    finish_run(len);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    flush = 1'b0;
    idle  = 1'b1;
    done  = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_val   = '0;
    repeat (3) @(negedge clk);

    checkOutput("rst_start",    32'(start),            32'd0);
    checkOutput("rst_cnt_val",  32'(cnt_val),          32'd0);
    checkOutput("rst_busy",     32'(busy),             32'd0);
    checkOutput("rst_fifo_cnt", 32'(fifo_cnt),         32'd0);
    checkOutput("rst_done_cnt", 32'(done_cnt),         32'd0);
    checkOutput("rst_timeout",  32'(timeout),          32'd0);
    checkOutput("rst_ready",    32'(cmd_if.cmd_ready), 32'd1);
    rst = 1'b0;

    // Single run of 5, done six cycles later, busy clears after the gap.
    applyStimulus(8'd5);
    checkOutput("t1_fifo_cnt", 32'(fifo_cnt), 32'd1);
    run_done(6);
    checkOutput("t1_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("t1_busy_gap", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("t1_busy_idle", 32'(busy), 32'd0);

    // Three queued commands launch in order.
    idle = 1'b0;
    applyStimulus(8'd3);
    applyStimulus(8'd7);
    applyStimulus(8'd2);
    checkOutput("t2_fifo_cnt", 32'(fifo_cnt), 32'd3);
    idle = 1'b1;
    run_done(3);
    run_done(7);
    run_done(2);
    checkOutput("t2_done_cnt", 32'(done_cnt), 32'd4);
    checkOutput("t2_starts", 32'(starts), 32'd4);

    // Fill to depth, fifth command stalls; a pop from full must not admit
    // the waiting command in the same cycle.
    idle = 1'b0;
    for (int v = 1; v <= 4; v++) applyStimulus(8'(v));
    checkOutput("t3_full_ready", 32'(cmd_if.cmd_ready), 32'd0);
    checkOutput("t3_full_cnt", 32'(fifo_cnt), 32'd4);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_val   = 8'd9;
    repeat (3) @(negedge clk);
    checkOutput("t3_held_cnt", 32'(fifo_cnt), 32'd4);
    checkOutput("t3_held_ready", 32'(cmd_if.cmd_ready), 32'd0);
    idle = 1'b1;
    @(negedge clk);
    checkOutput("t3_no_bypass", 32'(fifo_cnt), 32'd3);
    checkOutput("t3_ready_open", 32'(cmd_if.cmd_ready), 32'd1);
    sb_q.push_back(8'd9);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    checkOutput("t3_refill", 32'(fifo_cnt), 32'd4);
    finish_run(2);
    for (int r = 0; r < 4; r++) run_done(2);
    checkOutput("t3_done_cnt", 32'(done_cnt), 32'd9);
    checkOutput("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // Zero command is dropped without a launch.
    applyStimulus(8'd0);
    applyStimulus(8'd4);
    run_done(3);
    checkOutput("t4_done_cnt", 32'(done_cnt), 32'd10);
    checkOutput("t4_starts", 32'(starts), 32'd10);
    checkOutput("t4_fifo_cnt", 32'(fifo_cnt), 32'd0);

    // Flush mid-run with a colliding push; the run still completes.
    applyStimulus(8'd6);
    wait_start();
    applyStimulus(8'd1);
    applyStimulus(8'd2);
    applyStimulus(8'd3);
    checkOutput("t5_pre_flush", 32'(fifo_cnt), 32'd3);
    flush = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_val   = 8'd8;
    @(negedge clk);
    flush = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    checkOutput("t5_flush_cnt", 32'(fifo_cnt), 32'd0);
    sb_q.delete();
    finish_run(5);
    checkOutput("t5_done_cnt", 32'(done_cnt), 32'd11);
    repeat (8) @(negedge clk);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_starts", 32'(starts), 32'd11);

`ifdef CNT_CMD_SCHED_TIMEOUT_EN
    // Withheld done: watchdog fires 2^CNT_WIDTH+4 cycles after WAIT entry.
    applyStimulus(8'd3);
    wait_start();
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (timeout) break;
    end
    checkOutput("to_delay", 32'(n), 32'((2 ** CNT_WIDTH) + 5));
    checkOutput("to_done_cnt", 32'(done_cnt), 32'd11);
    @(negedge clk);
    checkOutput("to_pulse", 32'(timeout), 32'd0);
    repeat (4) @(negedge clk);
`else
    checkOutput("timeout_tied", 32'(timeout), 32'd0);
`endif

    // Asynchronous reset in the middle of WAIT.
    applyStimulus(8'd9);
    wait_start();
    applyStimulus(8'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_start",    32'(start),            32'd0);
    checkOutput("t6_busy",     32'(busy),             32'd0);
    checkOutput("t6_cnt_val",  32'(cnt_val),          32'd0);
    checkOutput("t6_fifo_cnt", 32'(fifo_cnt),         32'd0);
    checkOutput("t6_done_cnt", 32'(done_cnt),         32'd0);
    checkOutput("t6_ready",    32'(cmd_if.cmd_ready), 32'd1);
    checkOutput("t6_timeout",  32'(timeout),          32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'd5);
    run_done(2);
    checkOutput("t6_after_done_cnt", 32'(done_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnt_cmd_sched.md
Name: cnt_cmd_sched

Overview:
- Command sequencer directly upstream of the counter/read-FSM pair.
- Buffers count values from a producer in a small FIFO using a valid/ready handshake.
- Drives the counter's start and count-value inputs, one run at a time, and waits for each run's done pulse before launching the next.
- Reports occupancy, busy status and a completed-run tally.

Parameters:
- CNT_WIDTH, 8, width of count values; matches the downstream counter.
- FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- GAP_CYCLES, 1, idle cycles inserted after each done before the next launch; minimum 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  producer has a command.
- cmd_ready_o  out  1  FIFO can accept a command.
- cmd_val_i  in  CNT_WIDTH  requested count value.
- flush_i  in  1  synchronous FIFO clear.
- start_o  out  1  one-cycle launch pulse to the counter FSM.
- cnt_val_o  out  CNT_WIDTH  count value for the current run.
- idle_i  in  1  counter FSM reports IDLE.
- done_i  in  1  counter FSM done pulse.
- busy_o  out  1  a run is launched or in flight (LAUNCH/WAIT/GAP).
- fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- done_cnt_o  out  16  completed runs, wrapping at 2^16.
- timeout_o  out  1  watchdog pulse (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): FIFO empty; state IDLE. Output reset values: start_o=0, cnt_val_o=0, busy_o=0, fifo_cnt_o=0, done_cnt_o=0, timeout_o=0, cmd_ready_o=1.
- Push: occurs when cmd_valid_i && cmd_ready_o. cmd_ready_o = !full, registered-state based, with no same-cycle pop bypass: when full, a concurrent pop does not open ready that cycle.
- Zero-valued commands: accepted by the handshake and stored like any other entry. On pop they are discarded with no launch and no done_cnt change; the FSM stays in IDLE.
- FSM states IDLE, LAUNCH, WAIT, GAP:
  - IDLE: if FIFO non-empty and idle_i=1, pop the head into cnt_val_o. Nonzero value -> LAUNCH; zero -> stay in IDLE.
  - LAUNCH: start_o=1 for exactly this cycle -> WAIT.
  - WAIT: hold cnt_val_o stable. On done_i=1 -> increment done_cnt_o, go to GAP.
  - GAP: count GAP_CYCLES cycles -> IDLE.
- Latency: a command pushed at edge N into an empty FIFO is popped at edge N+1, and start_o is high during the cycle after edge N+1. The minimum start-to-start spacing is (run length + GAP_CYCLES + 2) cycles.
- done_i outside WAIT is ignored: no count, no state change.
- flush_i: empties the FIFO. It does not abort the run in progress and takes priority over a same-cycle push (the pushed command is dropped). A same-cycle pop still takes the head.
- Reset mid-run: everything returns to reset values immediately; no start_o glitch.
- Pointers: wrap modulo FIFO_DEPTH. Occupancy is tracked separately, so full and empty are unambiguous.

Optional Feature:
- Macro: CNT_CMD_SCHED_TIMEOUT_EN.
- Defined: a watchdog counts cycles in WAIT. If 2^CNT_WIDTH+4 cycles pass with no done_i:
  - timeout_o pulses for 1 cycle;
  - the FSM goes to GAP;
  - done_cnt_o is not incremented.
  The watchdog clears on entering WAIT.
- Undefined: no watchdog logic; timeout_o is tied to 0; WAIT lasts indefinitely.

Test Plan:
- Reset release, push 5 -> start_o pulses once with cnt_val_o=5. done_i asserted 6 cycles later -> done_cnt_o=1, busy_o drops after GAP_CYCLES.
- Push 3,7,2 back-to-back -> three start_o pulses in order with cnt_val_o=3,7,2; no launch before the prior done_i + GAP; done_cnt_o=3.
- Push 5 values with FIFO_DEPTH=4 while idle_i=0 -> cmd_ready_o=0 after 4 pushes, fifo_cnt_o=4, fifth value held by the producer until a pop.
- Push 0 then 4 -> no start_o for 0; single start_o with cnt_val_o=4; done_cnt_o=1.
- Fill 3 entries mid-run, assert flush_i -> fifo_cnt_o=0 next cycle; current run completes with done_cnt_o+1 and no further launches. Separately, assert rst mid-WAIT -> all outputs at reset values within the same cycle.
- With CNT_CMD_SCHED_TIMEOUT_EN, CNT_WIDTH=4: launch, withhold done_i -> timeout_o pulse 20 cycles after WAIT entry, done_cnt_o unchanged, next command launches after GAP.
